// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift execution stage.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_RSV = 2'b11
  } shift_op_e;

  localparam int max_rev_width = 64;

  // Reverses the low 'width' bits of value; bits at and above 'width' come back as zero.
  function automatic logic [max_rev_width-1:0] bit_reverse(
    input logic [max_rev_width-1:0] value,
    input int                       width
  );
    logic [max_rev_width-1:0] result;
    logic [5:0]               src_idx;
    result = '0;
    for (int i = 0; i < max_rev_width; i++) begin
      src_idx = 6'(width - 1 - i);
      if (i < width) begin
        result[i] = value[src_idx];
      end else begin
        result[i] = 1'b0;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_exec_stage_checker.sv
// Protocol properties of shift_exec_stage: output hold under stall, and
// acceptance whenever the first stage is empty.
module shift_exec_stage_checker #(
  parameter int nb_bits_data = 32,
  parameter int nb_bits_tag  = 5
) (
  input logic                    clk_i,
  input logic                    rst_i,
  input logic                    valid_o,
  input logic                    ready_i,
  input logic                    ready_o,
  input logic [nb_bits_data-1:0] data_o,
  input logic [nb_bits_tag-1:0]  tag_o,
  input logic                    s1_valid
);

  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> ($stable(data_o) && $stable(tag_o)))
    else $error("output changed while stalled");

  a_ready_when_s1_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !s1_valid |-> ready_o)
    else $error("ready_o low with stage 1 empty");

endmodule

// File: rtl/shifter_left_logical.sv
// Combinational logarithmic barrel shifter: logical left shift, zero fill.
module shifter_left_logical #(
  parameter int nb_bits_data  = 32,
  parameter int nb_bits_shift = 5
) (
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [nb_bits_shift-1:0] shift_value_i,
  output logic [nb_bits_data-1:0]  data_o
);

  logic [nb_bits_data-1:0] shifted;

  // One stage per amount bit, stage k shifts by 2**k.
  always_comb begin
    shifted = data_i;
    for (int k = 0; k < nb_bits_shift; k++) begin
      shifted = shift_value_i[k] ? (shifted << (1 << k)) : shifted;
    end
  end

  assign data_o = shifted;

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift unit: right shifts are done as left shifts on the
// bit-reversed operand, then reversed back and sign-filled for SRA.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int nb_bits_data  = 32,
  parameter int nb_bits_shift = 5,
  parameter int nb_bits_tag   = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [nb_bits_shift-1:0] shift_value_i,
  input  logic [nb_bits_tag-1:0]   tag_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [nb_bits_data-1:0]  data_o,
  output logic [nb_bits_tag-1:0]   tag_o,
  output logic                     err_o
);

  shift_op_e                op_in;
  logic [nb_bits_data-1:0]  operand_in;

  logic                     s1_valid;
  shift_op_e                s1_op;
  logic [nb_bits_tag-1:0]   s1_tag;
  logic [nb_bits_shift-1:0] s1_shift;
  logic                     s1_sign;
  logic [nb_bits_data-1:0]  s1_operand;

  logic                     s2_valid;
  logic [nb_bits_data-1:0]  s2_data;
  logic [nb_bits_tag-1:0]   s2_tag;
  logic                     s2_err;

  logic                     s2_adv;
  logic                     s1_adv;

  logic [nb_bits_data-1:0]  all_ones;
  logic [nb_bits_data-1:0]  shifted_data;
  logic [nb_bits_data-1:0]  shifted_mask;
  logic [nb_bits_data-1:0]  rev_data;
  logic [nb_bits_data-1:0]  rev_mask;
  logic [nb_bits_data-1:0]  result;
  logic                     result_err;

  assign s2_adv  = !s2_valid || ready_i;
  assign s1_adv  = !s1_valid || s2_adv;
  assign ready_o = s1_adv;

  assign op_in    = shift_op_e'(op_i);
  assign all_ones = '1;

  // Right shifts enter the shifter reversed so one left shifter serves all ops.
  always_comb begin
    operand_in = data_i;
    case (op_in)
      SHIFT_SRL: operand_in = nb_bits_data'(bit_reverse(max_rev_width'(data_i), nb_bits_data));
      SHIFT_SRA: operand_in = nb_bits_data'(bit_reverse(max_rev_width'(data_i), nb_bits_data));
      SHIFT_SLL: operand_in = data_i;
      SHIFT_RSV: operand_in = data_i;
      default:   operand_in = data_i;
    endcase
  end

  // Stage 1 operand register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s1_op      <= SHIFT_SLL;
      s1_tag     <= '0;
      s1_shift   <= '0;
      s1_sign    <= 1'b0;
      s1_operand <= '0;
    end else if (s1_adv) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_op      <= op_in;
        s1_tag     <= tag_i;
        s1_shift   <= shift_value_i;
        s1_sign    <= data_i[nb_bits_data-1];
        s1_operand <= operand_in;
      end
    end
  end

  shifter_left_logical #(
    .nb_bits_data (nb_bits_data),
    .nb_bits_shift(nb_bits_shift)
  ) u_shift_data (
    .data_i       (s1_operand),
    .shift_value_i(s1_shift),
    .data_o       (shifted_data)
  );

  // Mask of ones marks the bits that survive the shift; its complement is the SRA fill.
  shifter_left_logical #(
    .nb_bits_data (nb_bits_data),
    .nb_bits_shift(nb_bits_shift)
  ) u_shift_mask (
    .data_i       (all_ones),
    .shift_value_i(s1_shift),
    .data_o       (shifted_mask)
  );

  assign rev_data = nb_bits_data'(bit_reverse(max_rev_width'(shifted_data), nb_bits_data));
  assign rev_mask = nb_bits_data'(bit_reverse(max_rev_width'(shifted_mask), nb_bits_data));

  // Restore bit order and apply sign fill.
  always_comb begin
    result     = shifted_data;
    result_err = 1'b0;
    case (s1_op)
      SHIFT_SLL: result = shifted_data;
      SHIFT_SRL: result = rev_data;
      SHIFT_SRA: result = rev_data | (~rev_mask & {nb_bits_data{s1_sign}});
      SHIFT_RSV: begin
        result     = s1_operand;
        result_err = 1'b1;
      end
      default: begin
        result     = s1_operand;
        result_err = 1'b1;
      end
    endcase
  end

  // Stage 2 result register; holds while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= result;
        s2_tag  <= s1_tag;
        s2_err  <= result_err;
      end
    end
  end

  assign valid_o = s2_valid;
  assign data_o  = s2_data;
  assign tag_o   = s2_tag;
  assign err_o   = s2_err;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage with an arithmetic reference model and scoreboard.
module tb_shift_exec_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] data_i;
  logic [4:0]  shift_value_i;
  logic [4:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [4:0]  tag_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int out_count = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  shift_exec_stage #(.nb_bits_data(32), .nb_bits_shift(5), .nb_bits_tag(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .data_i(data_i), .shift_value_i(shift_value_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .tag_o(tag_o), .err_o(err_o)
  );

  shift_exec_stage_checker #(.nb_bits_data(32), .nb_bits_tag(5)) u_chk (
    .clk_i(clk_i), .rst_i(rst_i), .valid_o(valid_o), .ready_i(ready_i),
    .ready_o(ready_o), .data_o(data_o), .tag_o(tag_o), .s1_valid(dut.s1_valid)
  );

  // Reference: plain shift operators, reserved op passes the operand through.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] d,
                                               input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = $signed(d) >>> sh;
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard: push accepted requests, compare every output transfer, check stall hold.
  logic        have_prev = 1'b0;
  logic        prev_valid, prev_ready, prev_err;
  logic [31:0] prev_data;
  logic [4:0]  prev_tag;

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(valid_o), 32'd1);
        chk("hold_data", data_o, prev_data);
        chk("hold_tag", 32'(tag_o), 32'(prev_tag));
        chk("hold_err", 32'(err_o), 32'(prev_err));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("stale_output_valid", 32'(valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", data_o, e.data);
          chk("sb_tag", 32'(tag_o), 32'(e.tag));
          chk("sb_err", 32'(err_o), 32'(e.err));
          out_count++;
        end
      end
      if (valid_i && ready_o) begin
        e.data = model_result(op_i, data_i, shift_value_i);
        e.tag  = tag_i;
        e.err  = (op_i == 2'b11);
        exp_q.push_back(e);
      end
      prev_valid = valid_o;
      prev_ready = ready_i;
      prev_data  = data_o;
      prev_tag   = tag_o;
      prev_err   = err_o;
      have_prev  = 1'b1;
    end
  end

  int tag_seed = 1;

  // One request into an empty pipe; result must appear exactly two cycles later.
  task automatic single(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input logic [31:0] exp_data, input logic exp_err);
    logic [4:0] t;
    t = 5'(tag_seed);
    tag_seed++;
    chk({name, "_model"}, model_result(op, d, sh), exp_data);
    ready_i = 1'b1; valid_i = 1'b1; op_i = op; data_i = d; shift_value_i = sh; tag_i = t;
    step();
    valid_i = 1'b0;
    chk({name, "_early_valid"}, 32'(valid_o), 32'd0);
    step();
    chk({name, "_valid"}, 32'(valid_o), 32'd1);
    chk({name, "_data"}, data_o, exp_data);
    chk({name, "_tag"}, 32'(tag_o), 32'(t));
    chk({name, "_err"}, 32'(err_o), 32'(exp_err));
    step();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int idx;
    logic acc;
    logic [1:0]  bp_op[3];
    logic [31:0] bp_data[3];
    logic [4:0]  bp_sh[3];

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    op_i = 2'b00; data_i = 32'd0; shift_value_i = 5'd0; tag_i = 5'd0;
    step(); step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_data", data_o, 32'd0);
    chk("reset_tag", 32'(tag_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_ready", 32'(ready_o), 32'd1);
    step();

    single("sll_1_31",   2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    single("srl_msb_4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0);
    single("sra_msb_4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
    single("sra_pos_31", 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0);
    single("sra_neg_31", 2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 1'b0);
    single("sll_0",      2'b00, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 1'b0);
    single("srl_0",      2'b01, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 1'b0);
    single("sra_0",      2'b10, 32'hA5A5_0F0F, 5'd0,  32'hA5A5_0F0F, 1'b0);
    single("sll_8",      2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800, 1'b0);
    single("srl_8",      2'b01, 32'h1234_5678, 5'd8,  32'h0012_3456, 1'b0);
    single("rsv",        2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b1);

    // Back-to-back burst with the consumer always ready.
    base = out_count;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      op_i = 2'(i % 3);
      data_i = 32'h8123_4567 ^ (32'h0101_0101 * 32'(i));
      shift_value_i = 5'(i * 3 + 1);
      tag_i = 5'(16 + i);
      @(negedge clk_i);
      chk("b2b_ready", 32'(ready_o), 32'd1);
      step();
    end
    valid_i = 1'b0;
    drain("b2b");
    chk("b2b_count", 32'(out_count - base), 32'd8);

    // Backpressure: three requests offered while the consumer stalls for 5 cycles.
    bp_op[0] = 2'b00; bp_data[0] = 32'h0000_00FF; bp_sh[0] = 5'd4;
    bp_op[1] = 2'b01; bp_data[1] = 32'hFF00_0000; bp_sh[1] = 5'd8;
    bp_op[2] = 2'b10; bp_data[2] = 32'h8000_0000; bp_sh[2] = 5'd1;
    idx = 0;
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid_i = 1'b1; op_i = bp_op[idx]; data_i = bp_data[idx];
      shift_value_i = bp_sh[idx]; tag_i = 5'(8 + idx);
      @(negedge clk_i);
      acc = ready_o;
      chk("bp_ready", 32'(ready_o), (k < 2) ? 32'd1 : 32'd0);
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_head_valid", 32'(valid_o), 32'd1);
    chk("bp_head_data", data_o, 32'h0000_0FF0);
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", 32'(ready_o), 32'd1);
    step();
    valid_i = 1'b0;
    chk("bp_second_data", data_o, 32'h00FF_0000);
    step();
    chk("bp_third_data", data_o, 32'hC000_0000);
    drain("bp");

    // Reset with both stages occupied.
    ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid_i = 1'b1; op_i = 2'b00; data_i = 32'hDEAD_BEEF; shift_value_i = 5'(k + 1);
      tag_i = 5'(28 + k);
      step();
    end
    valid_i = 1'b0;
    chk("full_before_reset", 32'(valid_o), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_full_valid", 32'(valid_o), 32'd0);
    chk("rst_full_data", data_o, 32'd0);
    chk("rst_full_tag", 32'(tag_o), 32'd0);
    chk("rst_full_ready", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    for (int n = 0; n < 6; n++) step();
    chk("rst_no_stale", 32'(valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
